// File: rtl/aes_word_loader.sv
// aes_word_loader: wraps an AES core. Collects 32-bit plaintext and key words
// into 128-bit operands, runs the core with a bounded wait, then returns the
// 128-bit result as four 32-bit words, most significant word first. The key
// stays loaded across blocks, so only new plaintext is needed per block.
module aes_word_loader #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sel,
  input  logic [31:0]  in_data,
  output logic         AES_en,
  output logic [127:0] AES_data_in,
  output logic [127:0] AES_key_in,
  input  logic         AES_data_out_valid,
  input  logic [127:0] AES_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_t;

  localparam logic [15:0] LP_LAST_CYC = 16'(TIMEOUT_CYC - 1);

  state_t         r_state;
  state_t         w_next;
  logic [2:0]     r_data_cnt;
  logic [1:0]     r_key_cnt;
  logic           r_key_loaded;
  logic [15:0]    r_cyc_cnt;
  logic [1:0]     r_idx;
  logic [127:0]   r_data_in;
  logic [127:0]   r_key_in;
  logic [127:0]   r_result;
  logic           r_timeout_err;

  logic           w_in_ready;
  logic           w_data_acc;
  logic           w_key_acc;
  logic           w_launch;
  logic           w_done;
  logic           w_tmo;
  logic           w_out_hs;
  logic           w_drain_end;
  logic [1:0]     w_didx;

  // A fifth plaintext word is refused until the current block has drained;
  // key words are always welcome while loading.
  assign w_in_ready  = (r_state == ST_LOAD) & ~(~in_sel & (r_data_cnt == 3'd4));
  assign w_data_acc  = in_valid & w_in_ready & ~in_sel;
  assign w_key_acc   = in_valid & w_in_ready & in_sel;
  // Launch waits for a complete, stable key; a key word arriving on the same
  // edge would otherwise change the key underneath the running core.
  assign w_launch    = (r_state == ST_LOAD) & (r_data_cnt == 3'd4) & r_key_loaded & ~w_key_acc;
  assign w_done      = (r_state == ST_RUN) & AES_data_out_valid;
  assign w_tmo       = (r_state == ST_RUN) & ~AES_data_out_valid & (r_cyc_cnt == LP_LAST_CYC);
  assign w_out_hs    = (r_state == ST_DRAIN) & out_ready;
  assign w_drain_end = w_out_hs & (r_idx == 2'd3);
  assign w_didx      = r_data_cnt[1:0];

  assign in_ready    = w_in_ready;
  assign AES_en      = (r_state == ST_RUN);
  assign out_valid   = (r_state == ST_DRAIN);
  assign out_last    = (r_state == ST_DRAIN) & (r_idx == 2'd3);
  assign out_data    = (r_state == ST_DRAIN) ? r_result[{~r_idx, 5'd0} +: 32] : 32'd0;
  assign busy        = (r_state != ST_LOAD);
  assign AES_data_in = r_data_in;
  assign AES_key_in  = r_key_in;
  assign timeout_err = r_timeout_err;

  // State register; reset returns to loading with everything idle.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) r_state <= ST_LOAD;
    else            r_state <= w_next;
  end

  // Next-state logic: a valid result beats a timeout on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_launch) w_next = ST_RUN;
      ST_RUN: begin
        if (w_done)     w_next = ST_DRAIN;
        else if (w_tmo) w_next = ST_LOAD;
      end
      ST_DRAIN: if (w_drain_end) w_next = ST_LOAD;
      default:  w_next = ST_LOAD;
    endcase
  end

  // Operand assembly: words land MSW first; data count saturates at four.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_data_cnt   <= 3'd0;
      r_key_cnt    <= 2'd0;
      r_key_loaded <= 1'b0;
      r_data_in    <= 128'd0;
      r_key_in     <= 128'd0;
    end else begin
      if (w_data_acc) begin
        r_data_in[{~w_didx, 5'd0} +: 32] <= in_data;
        r_data_cnt                       <= r_data_cnt + 3'd1;
      end else if (w_tmo || w_drain_end) begin
        r_data_cnt <= 3'd0;
      end
      if (w_key_acc) begin
        r_key_in[{~r_key_cnt, 5'd0} +: 32] <= in_data;
        r_key_cnt                          <= r_key_cnt + 2'd1;
        if (r_key_cnt == 2'd0) r_key_loaded <= 1'b0;
        if (r_key_cnt == 2'd3) r_key_loaded <= 1'b1;
      end
    end
  end

  // Run-phase cycle counter, cleared whenever the core is not running.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n)               r_cyc_cnt <= 16'd0;
    else if (r_state != ST_RUN)   r_cyc_cnt <= 16'd0;
    else                          r_cyc_cnt <= r_cyc_cnt + 16'd1;
  end

  // Result capture and output word index for the drain phase.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_result <= 128'd0;
      r_idx    <= 2'd0;
    end else if (w_done) begin
      r_result <= AES_data_out;
      r_idx    <= 2'd0;
    end else if (w_out_hs) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Sticky timeout flag; a new timeout outranks a clear on the same edge.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n)   r_timeout_err <= 1'b0;
    else if (w_tmo)   r_timeout_err <= 1'b1;
    else if (err_clr) r_timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: drives aes_word_loader with a stub AES core that
// returns data^key after a programmable number of enable cycles. Expected
// result words are queued when a block is loaded and popped on each
// output handshake.
module tb_aes_word_loader;

  localparam logic [127:0] KEY1  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] KEY2  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] DATA1 = 128'h00000089_00000000_00000000_00000000;
  localparam logic [127:0] DATA2 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] DATA3 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] DATA4 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] DATA5 = 128'hdeadbeef_cafef00d_0badc0de_12345678;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sel;
  logic [31:0]  in_data;
  logic         AES_en;
  logic [127:0] AES_data_in, AES_key_in;
  logic         AES_data_out_valid;
  logic [127:0] AES_data_out;
  logic         out_valid, out_ready, out_last;
  logic [31:0]  out_data;
  logic         busy, timeout_err, err_clr;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] expQ[$];

  int enCnt = 0;
  int lastEnLen = 0;
  int enLaunches = 0;
  bit stubRespond = 1'b1;
  int stubLat = 50;

  aes_word_loader #(.TIMEOUT_CYC(255)) dut (
    .AES_clk(clk), .AES_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
    .AES_data_out_valid(AES_data_out_valid), .AES_data_out(AES_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stub core: counts enable cycles and pulses valid in the stubLat-th one.
  always @(negedge clk) begin
    if (!rst_n) begin
      enCnt = 0;
      AES_data_out_valid = 1'b0;
    end else if (AES_en) begin
      if (enCnt == 0) enLaunches++;
      enCnt++;
      AES_data_out_valid = stubRespond && (enCnt == stubLat);
      AES_data_out = AES_data_in ^ AES_key_in;
    end else begin
      if (enCnt != 0) lastEnLen = enCnt;
      enCnt = 0;
      AES_data_out_valid = 1'b0;
    end
  end

  // Scoreboard: every output handshake must match the next queued word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL out_word: got last=%b data=%h, required no word", out_last, out_data);
      end else begin
        logic [32:0] e;
        e = expQ.pop_front();
        if ({out_last, out_data} !== e) begin
          miscompares++;
          $display("[TB] FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic sendWord(input logic sel, input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_sel = sel; in_data = d;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        vectors++; miscompares++;
        $display("[TB] FAIL in_accept: got in_ready=%b after %0d cycles, required 1", in_ready, n);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic loadKey(input logic [127:0] k);
    for (int i = 0; i < 4; i++) sendWord(1'b1, k[127-32*i -: 32]);
  endtask

  task automatic loadData(input logic [127:0] d);
    for (int i = 0; i < 4; i++) sendWord(1'b0, d[127-32*i -: 32]);
  endtask

  task automatic pushExp(input logic [127:0] r);
    for (int i = 0; i < 4; i++) expQ.push_back({(i == 3), r[127-32*i -: 32]});
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < maxCyc) begin @(negedge clk); n++; end
    while (busy !== 1'b0 && n < maxCyc) begin @(negedge clk); n++; end
    if (n >= maxCyc) begin
      vectors++; miscompares++;
      $display("[TB] FAIL wait_idle: got busy=%b after %0d cycles, required a completed block", busy, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (AES_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_en: got %b, required 0", AES_en); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b, required 0", out_valid); end
    vectors++; if ({out_last, out_data} !== 33'd0) begin miscompares++; $display("[TB] FAIL rst_out_data: got %b %h, required 0", out_last, out_data); end
    vectors++; if ({busy, timeout_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_flags: got busy=%b err=%b, required 0 0", busy, timeout_err); end
    vectors++; if ({AES_data_in, AES_key_in} !== 256'd0) begin miscompares++; $display("[TB] FAIL rst_operands: got %h %h, required 0", AES_data_in, AES_key_in); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_basic();
    pushExp(DATA1 ^ KEY1);
    loadKey(KEY1);
    loadData(DATA1);
    vectors++; if (AES_key_in !== KEY1) begin miscompares++; $display("[TB] FAIL basic_key: got %h, required %h", AES_key_in, KEY1); end
    vectors++; if (AES_data_in !== DATA1) begin miscompares++; $display("[TB] FAIL basic_data: got %h, required %h", AES_data_in, DATA1); end
    waitIdle(400);
    vectors++; if (lastEnLen != 50) begin miscompares++; $display("[TB] FAIL basic_en_len: got %0d, required 50", lastEnLen); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL basic_words: got %0d missing, required 0", expQ.size()); end
  endtask

  task automatic test_key_reuse();
    int l0;
    l0 = enLaunches;
    pushExp(DATA2 ^ KEY1);
    loadData(DATA2);
    vectors++; if (AES_key_in !== KEY1) begin miscompares++; $display("[TB] FAIL reuse_key: got %h, required %h", AES_key_in, KEY1); end
    waitIdle(400);
    vectors++; if (enLaunches != l0 + 1) begin miscompares++; $display("[TB] FAIL reuse_launch: got %0d, required %0d", enLaunches, l0 + 1); end
    vectors++; if (lastEnLen != 50) begin miscompares++; $display("[TB] FAIL reuse_en_len: got %0d, required 50", lastEnLen); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL reuse_words: got %0d missing, required 0", expQ.size()); end
  endtask

  task automatic test_no_key();
    int l0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    l0 = enLaunches;
    loadData(DATA3);
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (enLaunches != l0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL nokey_no_en: got launches=%0d busy=%b, required %0d 0", enLaunches, busy, l0); end
    in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hffffffff;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL nokey_5th_refused: got in_ready=%b, required 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sel = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL nokey_key_ready: got in_ready=%b, required 1", in_ready); end
    vectors++; if (AES_data_in !== DATA3) begin miscompares++; $display("[TB] FAIL nokey_data: got %h, required %h", AES_data_in, DATA3); end
    @(posedge clk); #1;
    pushExp(DATA3 ^ KEY2);
    loadKey(KEY2);
    waitIdle(400);
    vectors++; if (enLaunches != l0 + 1) begin miscompares++; $display("[TB] FAIL nokey_launch: got %0d, required %0d", enLaunches, l0 + 1); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL nokey_words: got %0d missing, required 0", expQ.size()); end
  endtask

  task automatic test_timeout();
    stubRespond = 1'b0;
    loadData(DATA4);
    waitIdle(600);
    vectors++; if (lastEnLen != 255) begin miscompares++; $display("[TB] FAIL tmo_en_len: got %0d, required 255", lastEnLen); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err_set: got %b, required 1", timeout_err); end
    vectors++; if ({busy, out_valid, AES_en} !== 3'b000) begin miscompares++; $display("[TB] FAIL tmo_idle: got busy=%b out_valid=%b en=%b, required 000", busy, out_valid, AES_en); end
    in_sel = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_data_cnt_clr: got in_ready=%b, required 1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err_sticky: got %b, required 1", timeout_err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_err_clr: got %b, required 0", timeout_err); end
    // Response arrives in the very last permitted cycle: result must win.
    stubRespond = 1'b1;
    stubLat = 255;
    pushExp(DATA4 ^ KEY2);
    loadData(DATA4);
    waitIdle(600);
    stubLat = 50;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_valid_wins: got err=%b, required 0", timeout_err); end
    vectors++; if (lastEnLen != 255) begin miscompares++; $display("[TB] FAIL tmo_edge_en_len: got %0d, required 255", lastEnLen); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL tmo_edge_words: got %0d missing, required 0", expQ.size()); end
  endtask

  task automatic test_stall();
    logic [127:0] r;
    int n;
    r = DATA5 ^ KEY2;
    out_ready = 1'b0;
    pushExp(r);
    loadData(DATA5);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid: got %b, required 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_last, out_data} !== {2'b10, r[127:96]}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got v=%b l=%b d=%h, required v=1 l=0 d=%h", out_valid, out_last, out_data, r[127:96]);
      end
    end
    @(posedge clk); #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain_done: got busy=%b, required 0", busy); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL stall_words: got %0d missing, required 0", expQ.size()); end
  endtask

  task automatic test_reset_run();
    int n;
    // This block is aborted by reset, so no result words are expected.
    loadData(DATA1);
    n = 0;
    while (AES_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++; if ({AES_en, out_valid, busy, timeout_err} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rr_ctrl: got en=%b ov=%b busy=%b err=%b, required 0000", AES_en, out_valid, busy, timeout_err); end
    vectors++; if ({out_last, out_data, AES_data_in, AES_key_in} !== 289'd0) begin miscompares++; $display("[TB] FAIL rr_data: got %b %h %h %h, required 0", out_last, out_data, AES_data_in, AES_key_in); end
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pushExp(DATA2 ^ KEY1);
    loadKey(KEY1);
    loadData(DATA2);
    waitIdle(400);
    vectors++; if (lastEnLen != 50) begin miscompares++; $display("[TB] FAIL rr_en_len: got %0d, required 50", lastEnLen); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL rr_words: got %0d missing, required 0", expQ.size()); end
  endtask

  // Watchdog: a hung handshake must still end the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required completion before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'd0;
    out_ready = 1'b1; err_clr = 1'b0;
    AES_data_out_valid = 1'b0; AES_data_out = 128'd0;
    test_reset();
    test_basic();
    test_key_reuse();
    test_no_key();
    test_timeout();
    test_stall();
    test_reset_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Front/back-end adapter placed directly around AES_top.
- Upstream side: assembles 128-bit plaintext and key from 32-bit valid/ready word streams, then drives AES_en, AES_data_in and AES_key_in into the core.
- Downstream side: captures AES_data_out on AES_data_out_valid and streams the 128-bit result out as four 32-bit words.
- Key is retained across blocks, so a new key is loaded only when it changes.

Parameters:
TIMEOUT_CYC, 255, max RUN cycles waiting for AES_data_out_valid before abort (1..65535; 16-bit counter).

Ports:
AES_clk  in  1  clock, all logic on rising edge
AES_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_sel  in  1  0 = plaintext word, 1 = key word
in_data  in  32  input word, most-significant word first
AES_en  out  1  core enable, level, held for whole operation
AES_data_in  out  128  plaintext to core
AES_key_in  out  128  key to core
AES_data_out_valid  in  1  core result valid (pulse)
AES_data_out  in  128  core result
out_valid  out  1  result word valid
out_ready  in  1  result word consumed when out_valid & out_ready
out_data  out  32  result word, MSW first
out_last  out  1  high with 4th result word
busy  out  1  state != LOAD
timeout_err  out  1  sticky abort flag
err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- States: LOAD, RUN, DRAIN; reset state LOAD.
- Reset values: data_cnt = 0, key_cnt = 0, key_loaded = 0.
- Reset values: all data/key/result registers 0; AES_en, out_valid, out_last, out_data, busy, timeout_err all 0.
- Reset dominates: nothing is written while AES_rst_n = 0.
- in_ready = (state == LOAD) & !(in_sel == 0 & data_cnt == 4). Key words are always accepted in LOAD.
- Plaintext word k (k = data_cnt, 0..3) is written to AES_data_in[127-32k -: 32]. data_cnt saturates at 4.
- Key word k (k = key_cnt) is written to AES_key_in[127-32k -: 32]. key_cnt wraps 3->0.
  - Accepting key word 0 clears key_loaded.
  - Accepting key word 3 sets key_loaded.
- LOAD->RUN on the first edge where data_cnt == 4 & key_loaded (registered). AES_en goes high the cycle after that condition first holds.
- A key word accepted on the same edge as the 4th data word delays launch until key_loaded is set.
- RUN:
  - AES_en = 1; AES_data_in and AES_key_in are frozen; in_ready = 0.
  - cyc_cnt increments each cycle.
- AES_data_out_valid sampled high in RUN:
  - AES_data_out is latched into result.
  - Same edge: AES_en -> 0, state -> DRAIN, out_valid -> 1, word index 0.
- Timeout: cyc_cnt == TIMEOUT_CYC - 1 with no valid:
  - timeout_err -> 1, AES_en -> 0, state -> LOAD.
  - data_cnt -> 0; key kept; no output produced.
- Valid and timeout on the same edge: valid wins, no error.
- AES_data_out_valid outside RUN is ignored.
- DRAIN:
  - out_data = result word idx (idx 0 = bits 127:96); out_last = (idx == 3).
  - Each handshake increments idx. out_data and out_valid stay stable while out_ready = 0.
  - Handshake on idx 3 -> state LOAD, out_valid 0, data_cnt 0.
- err_clr clears timeout_err. If err_clr and a timeout occur on the same edge, set wins.
- Throughput: 4 load cycles + core latency + 4 drain cycles per block when no stalls occur.
- Reset mid-operation: AES_en and out_valid drop immediately (async). The key must be reloaded afterwards.

Test Plan:
- Load key words aa2bdb40, bff6a5e8, caa9ba3e, bc1e2acc, then data 00000089, 0, 0, 0. Stub core returns data^key after 50 cycles.
  - AES_key_in and AES_data_in match those words.
  - AES_en is high for exactly 50 cycles.
  - Output words are aa2bdbc9, bff6a5e8, caa9ba3e, bc1e2acc, with out_last on the 4th.
- Second block a6f2daeb_140fa720_529e75d5_21cbc681 with no key reload -> key reused, AES_en pulses again, result = data^aa2bdb40_... .
- Four data words with no key after reset:
  - No AES_en.
  - A 5th data word is refused (in_ready 0 for in_sel = 0).
  - Loading the key then launches.
- Stub never responds, TIMEOUT_CYC = 255:
  - AES_en is high for exactly 255 cycles.
  - timeout_err = 1, state returns to LOAD, data_cnt = 0.
  - err_clr clears timeout_err.
- out_ready held low 10 cycles during DRAIN, then toggled every other cycle -> words are not skipped or duplicated, and out_data is stable while stalled.
- AES_rst_n pulled low 20 cycles into RUN:
  - All outputs are 0 immediately.
  - After release, a key-plus-data reload completes normally.
